// File: rtl/shift_pkg.sv
// Shared types for the sequential shift unit: operation codes, FSM states
// and a width helper for the per-cycle shift amount.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_ROTR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } shift_state_t;

  // Bits needed to hold a per-cycle shift amount in 0..step
  function automatic int unsigned step_k_width(input int unsigned step);
    return $clog2(step + 1);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single combinational shift stage: shifts WIDTH bits by k (0..STEP).
// Rotate-right support is built only when SEQ_SHIFT_ROTATE_EN is defined;
// otherwise op 11 falls through to the SLL path.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  localparam int unsigned KW   = step_k_width(STEP)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result
);

`ifdef SEQ_SHIFT_ROTATE_EN
  localparam int unsigned RW = $clog2(WIDTH) + 1;

  logic [RW-1:0] rot_left;

  // Left-shift amount that brings the low k bits round to the top
  assign rot_left = RW'(WIDTH) - RW'(k);
`endif

  // One shift step for the selected operation
  always_comb begin
    result = data << k;
    case (op)
      SH_SRL:  result = data >> k;
      SH_SRA:  result = WIDTH'($signed(data) >>> k);
`ifdef SEQ_SHIFT_ROTATE_EN
      SH_ROTR: result = (data >> k) | (data << rot_left);
`endif
      default: result = data << k;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit, shifting at most STEP bits per cycle, with
// valid/ready handshakes on both sides and a synchronous flush.
// Define SEQ_SHIFT_ROTATE_EN to make op 11 a rotate-right; without it op 11
// is treated as SLL and no rotate logic is built.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP    = 4,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int unsigned KW = step_k_width(STEP);
  localparam int unsigned CW = SHAMT_W + 1;

  shift_state_t       state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   out_data_d;
  logic               in_ready_d;
  logic               out_valid_d;
  logic               busy_d;

  logic [KW-1:0]      step_k;
  logic [SHAMT_W-1:0] rem_after;
  logic [WIDTH-1:0]   step_res;

  // Map the requested op onto what this build implements
  function automatic logic [1:0] decode_op(input logic [1:0] op);
`ifdef SEQ_SHIFT_ROTATE_EN
    return op;
`else
    return (op == 2'(SH_ROTR)) ? 2'(SH_SLL) : op;
`endif
  endfunction

  // Bits to shift this cycle: min(STEP, remaining), and what is left after
  always_comb begin
    step_k = KW'(rem_q);
    if (CW'(rem_q) >= CW'(STEP)) begin
      step_k = KW'(STEP);
    end
    rem_after = SHAMT_W'(CW'(rem_q) - CW'(step_k));
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data   (work_q),
    .k      (step_k),
    .op     (op_q),
    .result (step_res)
  );

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    rem_d      = rem_q;
    op_d       = op_q;
    out_data_d = out_data;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          work_d = in_data;
          rem_d  = in_shamt;
          op_d   = decode_op(in_op);
          if (in_shamt == '0) begin
            state_d    = S_DONE;
            out_data_d = in_data;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = step_res;
        rem_d  = rem_after;
        // The step that empties the counter also publishes the result
        if (rem_after == '0) begin
          state_d    = S_DONE;
          out_data_d = step_res;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush aborts everything but leaves the last published result visible
    if (flush) begin
      state_d    = S_IDLE;
      out_data_d = out_data;
    end

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      work_q    <= '0;
      rem_q     <= '0;
      op_q      <= '0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      rem_q     <= rem_d;
      op_q      <= op_d;
      out_data  <= out_data_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: main instance with STEP=4 plus STEP=1
// and STEP=32 instances for latency scaling. Expected op-11 result follows
// SEQ_SHIFT_ROTATE_EN.
module tb_seq_shift_unit;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv [3];
  logic        ir [3];
  logic        ov [3];
  logic        bz [3];
  logic [31:0] od [3];
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        flush;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_shift_unit #(.WIDTH(32), .STEP(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .flush(flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0])
  );

  seq_shift_unit #(.WIDTH(32), .STEP(1)) u_dut_s1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .flush(flush),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1])
  );

  seq_shift_unit #(.WIDTH(32), .STEP(32)) u_dut_s32 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .flush(flush),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bz[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request to instance u and wait (bounded) for its result
  task automatic run_op(input int u, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] sh, output int lat, output logic [31:0] res);
    int guard;
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
    guard    = 0;
    while (!ir[u] && guard < 20) begin
      tick();
      guard++;
    end
    check("accept_ready", 32'(ir[u]), 32'd1);
    iv[u] = 1'b1;
    tick();
    iv[u]    = 1'b0;
    in_data  = ~d;
    in_shamt = ~sh;
    in_op    = ~op;
    lat = 1;
    while (!ov[u] && lat < 100) begin
      tick();
      lat++;
    end
    res = od[u];
  endtask

  task automatic consume(input int u);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_consume", 32'(ir[u]), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic [7:0]  pat;
    logic [31:0] exp_op3_a;
    logic [31:0] exp_op3_b;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;
    in_data = '0; in_shamt = '0; in_op = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_in_ready", 32'(ir[0]), 32'd1);
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_out_data", od[0], 32'd0);
    check("rst_busy", 32'(bz[0]), 32'd0);
    #2 reset = 1'b0;
    tick();

    // Legacy <<2 path
    run_op(0, SH_SLL, 32'h0000_0001, 5'd2, lat, res);
    check("sll2_lat", 32'(lat), 32'd2);
    check("sll2_data", res, 32'h0000_0004);
    consume(0);

    // Back-to-back <<2 with out_ready held high: one result every 3 cycles
    in_op = SH_SLL; in_data = 32'h0000_0001; in_shamt = 5'd2;
    iv[0] = 1'b1; out_ready = 1'b1;
    pat = 8'b1001_0010;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("b2b_valid", 32'(ov[0]), 32'(pat[i]));
      if (pat[i]) check("b2b_data", od[0], 32'h0000_0004);
    end
    iv[0] = 1'b0;
    tick();
    out_ready = 1'b0;
    check("b2b_drained", 32'(ir[0]), 32'd1);

    // Full-range right shifts
    run_op(0, SH_SRA, 32'h8000_0000, 5'd31, lat, res);
    check("sra31_lat", 32'(lat), 32'd9);
    check("sra31_data", res, 32'hFFFF_FFFF);
    consume(0);
    run_op(0, SH_SRL, 32'h8000_0000, 5'd31, lat, res);
    check("srl31_lat", 32'(lat), 32'd9);
    check("srl31_data", res, 32'h0000_0001);
    consume(0);
    run_op(0, SH_SRA, 32'h7FFF_FFF0, 5'd4, lat, res);
    check("sra_pos_lat", 32'(lat), 32'd2);
    check("sra_pos_data", res, 32'h07FF_FFFF);
    consume(0);
    run_op(0, SH_SLL, 32'h0000_0003, 5'd31, lat, res);
    check("sll31_lat", 32'(lat), 32'd9);
    check("sll31_data", res, 32'h8000_0000);
    consume(0);

    // Zero shift amount and consumer backpressure
    run_op(0, SH_SRL, 32'hDEAD_BEEF, 5'd0, lat, res);
    check("sh0_lat", 32'(lat), 32'd1);
    check("sh0_data", res, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(ov[0]), 32'd1);
      check("hold_data", od[0], 32'hDEAD_BEEF);
      check("hold_in_ready", 32'(ir[0]), 32'd0);
      check("hold_busy", 32'(bz[0]), 32'd1);
    end
    consume(0);

    // Flush in the second SHIFT cycle
    in_op = SH_SLL; in_data = 32'h0000_0001; in_shamt = 5'd12;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    check("fl_busy", 32'(bz[0]), 32'd1);
    check("fl_valid0", 32'(ov[0]), 32'd0);
    tick();
    check("fl_valid1", 32'(ov[0]), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_in_ready", 32'(ir[0]), 32'd1);
    check("fl_busy_after", 32'(bz[0]), 32'd0);
    check("fl_data_hold", od[0], 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_valid", 32'(ov[0]), 32'd0);
    end

    // Flush beats a request in IDLE
    flush = 1'b1; iv[0] = 1'b1;
    in_op = SH_SLL; in_data = 32'h0000_0005; in_shamt = 5'd0;
    tick();
    flush = 1'b0; iv[0] = 1'b0;
    check("fl_idle_ready", 32'(ir[0]), 32'd1);
    check("fl_idle_valid", 32'(ov[0]), 32'd0);

    // Request after flush completes normally
    run_op(0, SH_SRL, 32'h0000_00F0, 5'd4, lat, res);
    check("post_fl_lat", 32'(lat), 32'd2);
    check("post_fl_data", res, 32'h0000_000F);
    consume(0);

    // Asynchronous reset in the middle of SHIFT
    in_op = SH_SRA; in_data = 32'h8000_0000; in_shamt = 5'd31;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick(); tick();
    #3 reset = 1'b1;
    #1;
    check("arst_in_ready", 32'(ir[0]), 32'd1);
    check("arst_valid", 32'(ov[0]), 32'd0);
    check("arst_data", od[0], 32'd0);
    check("arst_busy", 32'(bz[0]), 32'd0);
    #2 reset = 1'b0;
    tick();
    check("arst_stays_idle", 32'(ov[0]), 32'd0);

    // Op 11: rotate right when enabled, SLL otherwise
`ifdef SEQ_SHIFT_ROTATE_EN
    exp_op3_a = 32'h8000_0000;
    exp_op3_b = 32'h0F00_0000;
`else
    exp_op3_a = 32'h0000_0002;
    exp_op3_b = 32'h0000_0F00;
`endif
    run_op(0, 2'b11, 32'h0000_0001, 5'd1, lat, res);
    check("op3_lat", 32'(lat), 32'd2);
    check("op3_data", res, exp_op3_a);
    consume(0);
    run_op(0, 2'b11, 32'h0000_000F, 5'd8, lat, res);
    check("op3b_lat", 32'(lat), 32'd3);
    check("op3b_data", res, exp_op3_b);
    consume(0);

    // STEP=1: latency 1+shamt
    run_op(1, SH_SRL, 32'h8000_0000, 5'd5, lat, res);
    check("s1_lat", 32'(lat), 32'd6);
    check("s1_data", res, 32'h0400_0000);
    consume(1);

    // STEP=32: latency 2 for any nonzero shamt
    run_op(2, SH_SRA, 32'h8000_0000, 5'd31, lat, res);
    check("s32_lat", 32'(lat), 32'd2);
    check("s32_data", res, 32'hFFFF_FFFF);
    consume(2);
    run_op(2, SH_SLL, 32'h0000_0001, 5'd2, lat, res);
    check("s32_sll_lat", 32'(lat), 32'd2);
    check("s32_sll_data", res, 32'h0000_0004);
    consume(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
